// File: rtl/wide_addsub_acc_pipe.sv
// Pipelined wide add/sub/accumulate unit with a valid/ready handshake and a persistent accumulator.
// Stage 1 does the arithmetic; later stages only delay. The whole pipe stalls together on backpressure.
module wide_addsub_acc_pipe #(
  parameter int WIDTH          = 47,
  parameter int PIPELINE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  op_e                 op_sel;
  logic                adv;
  logic                accept;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    s1_result;
  logic                s1_carry;
  logic                acc_we;
  logic [WIDTH-1:0]    acc_q;

  logic [WIDTH-1:0]          data_q  [PIPELINE_DEPTH];
  logic                      carry_q [PIPELINE_DEPTH];
  logic [PIPELINE_DEPTH-1:0] valid_q;

  assign op_sel   = op_e'(op);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    sum      = '0;
    s1_carry = 1'b0;
    acc_we   = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        s1_carry = sum[WIDTH];
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is "no borrow", so the borrow is its inverse.
        sum      = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        s1_carry = ~sum[WIDTH];
      end
      OP_ACC: begin
        sum      = {1'b0, acc_q} + {1'b0, a};
        s1_carry = sum[WIDTH];
        acc_we   = 1'b1;
      end
      OP_LOAD: begin
        sum      = {1'b0, a};
        s1_carry = 1'b0;
        acc_we   = 1'b1;
      end
    endcase
    s1_result = sum[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept && acc_we) begin
      acc_q <= s1_result;
    end
  end

  // NOTE: the delay stages are explicit flops, not a RAM, so resetting every entry is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < PIPELINE_DEPTH; i++) begin
        data_q[i]  <= '0;
        carry_q[i] <= 1'b0;
      end
    end else if (adv) begin
      valid_q[0] <= accept;
      data_q[0]  <= s1_result;
      carry_q[0] <= s1_carry;
      for (int i = 1; i < PIPELINE_DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        carry_q[i] <= carry_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[PIPELINE_DEPTH-1];
  assign out       = data_q[PIPELINE_DEPTH-1];
  assign carry_out = carry_q[PIPELINE_DEPTH-1];

endmodule

// File: tb/tb_wide_addsub_acc_pipe.sv
// Self-checking bench for wide_addsub_acc_pipe (WIDTH=47, PIPELINE_DEPTH=2): directed vectors,
// a backpressure stream and a randomised handshake stream against a small reference model.
module tb_wide_addsub_acc_pipe;
  localparam int W = 47;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry_out;

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    logic [W:0] exp;
    int         adv_at;
  } pend_t;

  pend_t        pend_q[$];
  logic [W-1:0] m_acc;
  int           adv_cnt;
  logic [W-1:0] max_v;

  wide_addsub_acc_pipe #(.WIDTH(W), .PIPELINE_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_acc = '0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model: carry for add/acc, borrow (a<b) for sub, 0 for load.
  function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    case (o)
      2'b00:   r = {1'b0, x} + {1'b0, y};
      2'b01:   r = {(x < y), x - y};
      2'b10: begin
        r     = {1'b0, m_acc} + {1'b0, x};
        m_acc = r[W-1:0];
      end
      default: begin
        r     = {1'b0, x};
        m_acc = x;
      end
    endcase
    return r;
  endfunction

  // Cycle-driven stream: rnd=0 is the 4-add backpressure case, rnd=1 random ops and handshakes.
  task automatic run_stream(input int n, input bit rnd);
    int         sent  = 0;
    int         got   = 0;
    int         cyc   = 0;
    int         stall = 0;
    bit         hold  = 0;
    bit         acc_now;
    bit         hs;
    logic [W:0] held = '0;
    pend_t      e;
    pend_q.delete();
    while (got < n && cyc < 3000) begin
      if (sent < n) begin
        if (rnd) begin
          drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                {15'($urandom), 32'($urandom)}, {15'($urandom), 32'($urandom)});
        end else begin
          drive(1'b1, 2'b00, W'(sent * 100 + 1), W'(sent + 2));
        end
      end else begin
        drive(1'b0, 2'b00, '0, '0);
      end
      if (rnd) out_ready = $urandom_range(0, 2) != 0;
      else if (out_valid && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else out_ready = 1'b1;
      #1;
      check("in_ready", in_ready, !out_valid || out_ready);
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {carry_out, out}, held);
      end
      acc_now = in_valid && in_ready;
      hs      = out_valid && out_ready;
      if (acc_now) begin
        pend_q.push_back('{exp: model(op, a, b), adv_at: adv_cnt});
        sent++;
      end
      if (hs) begin
        check("out_expected", pend_q.size() != 0, 1);
        if (pend_q.size() != 0) begin
          e = pend_q.pop_front();
          check("stream_data", {carry_out, out}, e.exp);
          check("stream_latency", adv_cnt - e.adv_at, D);
        end
        got++;
      end
      hold = out_valid && !out_ready;
      held = {carry_out, out};
      if (!out_valid || out_ready) adv_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    drive(1'b0, 2'b00, '0, '0);
    out_ready = 1'b1;
    check("stream_count", got, n);
    check("stream_leftover", pend_q.size(), 0);
  endtask

  initial begin
    max_v     = '1;
    adv_cnt   = 0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    do_reset();

    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_in_ready", in_ready, 1);

    // Reset mid-stream with two transactions in flight.
    drive(1'b1, 2'b00, 47'd1, 47'd2);
    tick();
    drive(1'b1, 2'b11, 47'd9, 47'd0);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    check("pre_rst_out", out, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_out", out, 0);
    check("async_rst_carry", carry_out, 0);
    #10;
    rst_n = 1'b1;
    m_acc = '0;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    drive(1'b1, 2'b10, 47'd5, 47'd0);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    check("acc5_not_yet", out_valid, 0);
    tick();
    check("acc5_valid", out_valid, 1);
    check("acc5_out", out, 5);
    tick();
    check("no_ghost", out_valid, 0);

    // Add wrap, latency 2.
    drive(1'b1, 2'b00, max_v, 47'd1);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    check("wrap_lat1", out_valid, 0);
    tick();
    check("wrap_valid", out_valid, 1);
    check("wrap_out", out, 0);
    check("wrap_carry", carry_out, 1);

    // Subtract: borrow, no borrow, equal operands.
    drive(1'b1, 2'b01, 47'd3, 47'd5);
    tick();
    drive(1'b1, 2'b01, 47'd5, 47'd3);
    tick();
    drive(1'b1, 2'b01, 47'd7, 47'd7);
    check("sub_borrow_out", out, 64'h7FFF_FFFF_FFFE);
    check("sub_borrow_c", carry_out, 1);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    check("sub_pos_out", out, 2);
    check("sub_pos_c", carry_out, 0);
    tick();
    check("sub_eq_out", out, 0);
    check("sub_eq_c", carry_out, 0);

    // Accumulate chain with an interleaved add.
    drive(1'b1, 2'b11, 47'd10, 47'd99);
    tick();
    drive(1'b1, 2'b10, 47'd7, 47'd99);
    tick();
    check("acc_load", out, 10);
    drive(1'b1, 2'b10, 47'd8, 47'd0);
    tick();
    check("acc_17", out, 17);
    drive(1'b1, 2'b00, 47'd1, 47'd1);
    tick();
    check("acc_25", out, 25);
    check("acc_25_valid", out_valid, 1);
    drive(1'b1, 2'b10, 47'd0, 47'd0);
    tick();
    check("mid_add", out, 2);
    drive(1'b0, 2'b00, '0, '0);
    tick();
    check("acc_kept", out, 25);

    // Accumulator wrap sets carry; load reports carry 0.
    drive(1'b1, 2'b11, max_v, 47'd0);
    tick();
    drive(1'b1, 2'b10, 47'd1, 47'd0);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    check("load_max", out, 64'h7FFF_FFFF_FFFF);
    check("load_carry", carry_out, 0);
    tick();
    check("acc_wrap_out", out, 0);
    check("acc_wrap_c", carry_out, 1);
    tick();

    // Backpressure stream, then randomised stream from a clean reset.
    run_stream(4, 1'b0);
    do_reset();
    run_stream(300, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
